// File: rtl/gauss5x5_filter.sv
// rtl/gauss5x5_filter.sv - serial 5x5 Gaussian smoothing MAC fed by the window buffer
// Accumulates one weighted tap per cycle, then emits a rounded pixel and clears the buffer.
module gauss5x5_filter #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int SHIFT  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_full,
   input  logic              i_empty,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_m1,
   input  logic [DATA_W-1:0] i_m2,
   input  logic [DATA_W-1:0] i_m3,
   input  logic [DATA_W-1:0] i_m4,
   input  logic [DATA_W-1:0] i_m5,
   input  logic [DATA_W-1:0] i_m6,
   input  logic [DATA_W-1:0] i_m7,
   input  logic [DATA_W-1:0] i_m8,
   input  logic [DATA_W-1:0] i_m9,
   input  logic [DATA_W-1:0] i_m10,
   input  logic [DATA_W-1:0] i_m11,
   input  logic [DATA_W-1:0] i_m12,
   input  logic [DATA_W-1:0] i_m13,
   input  logic [DATA_W-1:0] i_m14,
   input  logic [DATA_W-1:0] i_m15,
   input  logic [DATA_W-1:0] i_m16,
   input  logic [DATA_W-1:0] i_m17,
   input  logic [DATA_W-1:0] i_m18,
   input  logic [DATA_W-1:0] i_m19,
   input  logic [DATA_W-1:0] i_m20,
   input  logic [DATA_W-1:0] i_m21,
   input  logic [DATA_W-1:0] i_m22,
   input  logic [DATA_W-1:0] i_m23,
   input  logic [DATA_W-1:0] i_m24,
   input  logic [DATA_W-1:0] i_m25,
   output logic              o_clear,
   output logic              o_busy,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_ACCUM      = 2'd1;
   localparam logic [1:0] S_OUTPUT     = 2'd2;
   localparam logic [1:0] S_WAIT_EMPTY = 2'd3;

   logic [1:0]        state;
   logic [4:0]        idx;
   logic [ACC_W-1:0]  acc;
   logic [DATA_W-1:0] pix [25];
   logic [2:0]        row;
   logic [2:0]        col;
   logic [5:0]        coef;
   logic [ACC_W-1:0]  term;
   logic [ACC_W:0]    rounded;
   logic [DATA_W-1:0] result;

   // Separable binomial weights {1,4,6,4,1}; outer product gives the 5x5 kernel.
   function automatic logic [5:0] weight(input logic [2:0] k);
      case (k)
         3'd0, 3'd4: weight = 6'd1;
         3'd1, 3'd3: weight = 6'd4;
         default:    weight = 6'd6;
      endcase
   endfunction

   always_comb begin
      pix[0]  = i_m1;  pix[1]  = i_m2;  pix[2]  = i_m3;  pix[3]  = i_m4;  pix[4]  = i_m5;
      pix[5]  = i_m6;  pix[6]  = i_m7;  pix[7]  = i_m8;  pix[8]  = i_m9;  pix[9]  = i_m10;
      pix[10] = i_m11; pix[11] = i_m12; pix[12] = i_m13; pix[13] = i_m14; pix[14] = i_m15;
      pix[15] = i_m16; pix[16] = i_m17; pix[17] = i_m18; pix[18] = i_m19; pix[19] = i_m20;
      pix[20] = i_m21; pix[21] = i_m22; pix[22] = i_m23; pix[23] = i_m24; pix[24] = i_m25;
   end

   always_comb begin
      row     = 3'(idx / 5'd5);
      col     = 3'(idx % 5'd5);
      coef    = weight(row) * weight(col);
      term    = ACC_W'(coef) * ACC_W'(pix[idx]);
      rounded = {1'b0, acc} + (ACC_W + 1)'(1 << (SHIFT - 1));
      result  = DATA_W'(rounded >> SHIFT);
   end

   assign o_busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= 5'd0;
         acc     <= '0;
         o_clear <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_clear <= 1'b0;
         o_valid <= 1'b0;
         // Flush overrides every state, including a simultaneous full flag.
         if (i_flush) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_full) begin
                     state <= S_ACCUM;
                     acc   <= '0;
                     idx   <= 5'd0;
                  end
               end
               S_ACCUM: begin
                  acc <= acc + term;
                  idx <= idx + 5'd1;
                  if (idx == 5'd24) state <= S_OUTPUT;
               end
               S_OUTPUT: begin
                  o_valid <= 1'b1;
                  o_clear <= 1'b1;
                  o_data  <= result;
                  state   <= S_WAIT_EMPTY;
               end
               default: begin
                  // Wait for the buffer to really drain so a stale full flag cannot retrigger.
                  if (i_empty && !i_full) state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gauss5x5_filter.sv
// tb/tb_gauss5x5_filter.sv - self-checking bench for gauss5x5_filter
// Directed and random windows compared against a plain-arithmetic kernel model.
module tb_gauss5x5_filter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_full = 1'b0;
   logic       i_empty = 1'b1;
   logic       i_flush = 1'b0;
   logic [7:0] pix [25];
   logic       o_clear;
   logic       o_busy;
   logic       o_valid;
   logic [7:0] o_data;

   int checks = 0;
   int errors = 0;
   int last_data = 0;
   int w [5] = '{1, 4, 6, 4, 1};

   always #5 clk = ~clk;

   gauss5x5_filter #(.DATA_W(8), .ACC_W(16), .SHIFT(8)) dut (
      .clk(clk), .rst(rst), .i_full(i_full), .i_empty(i_empty), .i_flush(i_flush),
      .i_m1(pix[0]),   .i_m2(pix[1]),   .i_m3(pix[2]),   .i_m4(pix[3]),   .i_m5(pix[4]),
      .i_m6(pix[5]),   .i_m7(pix[6]),   .i_m8(pix[7]),   .i_m9(pix[8]),   .i_m10(pix[9]),
      .i_m11(pix[10]), .i_m12(pix[11]), .i_m13(pix[12]), .i_m14(pix[13]), .i_m15(pix[14]),
      .i_m16(pix[15]), .i_m17(pix[16]), .i_m18(pix[17]), .i_m19(pix[18]), .i_m20(pix[19]),
      .i_m21(pix[20]), .i_m22(pix[21]), .i_m23(pix[22]), .i_m24(pix[23]), .i_m25(pix[24]),
      .o_clear(o_clear), .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model();
      int s = 0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            s += w[r] * w[c] * int'(pix[r*5 + c]);
      return (s + 128) >> 8;
   endfunction

   task automatic fill(input int v);
      for (int i = 0; i < 25; i++) pix[i] = 8'(v);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 25; i++) pix[i] = 8'($urandom_range(0, 255));
   endtask

   // Present a full window, wait for the strobe, hold the stale flags, then drain.
   task automatic run_window(input string tag, input int exp_data, input int hold);
      int n = 0;
      int busy_low = 0;
      int extra_valid = 0;
      i_full  = 1'b1;
      i_empty = 1'b0;
      tick();
      while (n < 40) begin
         if (!o_busy) busy_low++;
         tick();
         n++;
         if (o_valid) break;
      end
      chk({tag, "_latency"}, n, 26);
      chk({tag, "_busy"}, busy_low, 0);
      chk({tag, "_clear"}, o_clear, 1);
      chk({tag, "_data"}, o_data, exp_data);
      last_data = exp_data;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (o_valid || o_clear || !o_busy) extra_valid++;
      end
      chk({tag, "_hold"}, extra_valid, 0);
      i_full  = 1'b0;
      i_empty = 1'b1;
      tick();
      chk({tag, "_idle"}, o_busy, 0);
   endtask

   initial begin
      fill(0);
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", o_valid, 0);
      chk("rst_clear", o_clear, 0);
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);

      fill(100);
      run_window("flat100", 100, 1);
      fill(255);
      run_window("flat255", 255, 1);
      fill(0);
      pix[12] = 8'd200;
      run_window("centre200", 28, 1);
      fill(0);
      pix[0] = 8'd255;
      run_window("corner255", 1, 1);

      // Flush at tap 10, with full still asserted.
      fill_random();
      i_full  = 1'b1;
      i_empty = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) tick();
      chk("flush_busy_before", o_busy, 1);
      i_flush = 1'b1;
      tick();
      chk("flush_busy", o_busy, 0);
      chk("flush_valid", o_valid, 0);
      chk("flush_clear", o_clear, 0);
      chk("flush_data", o_data, last_data);
      i_flush = 1'b0;
      i_full  = 1'b0;
      i_empty = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (o_valid || o_clear) chk("flush_late_valid", {o_valid, o_clear}, 0);
      end
      chk("flush_idle", o_busy, 0);

      // Reset at tap 20, then a fresh window must not see the partial sum.
      fill(255);
      i_full  = 1'b1;
      i_empty = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      i_full  = 1'b0;
      i_empty = 1'b1;
      chk("midrst_busy", o_busy, 0);
      chk("midrst_valid", o_valid, 0);
      chk("midrst_clear", o_clear, 0);
      chk("midrst_data", o_data, 0);
      tick();
      fill_random();
      run_window("after_rst", model(), 1);

      // Buffer ignores the clear: stale full must not retrigger.
      fill_random();
      run_window("stale_full", model(), 12);

      for (int k = 0; k < 6; k++) begin
         fill_random();
         run_window($sformatf("rand%0d", k), model(), 1 + k);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
